// File: rtl/sel_pipe_mux_if.sv
// sel_pipe_mux_if: upstream/downstream signal bundle for sel_pipe_mux.
// The master modport is the side that offers beats and consumes results.
// The slave modport is the mux itself.
interface sel_pipe_mux_if #(
    parameter int WIDTH = 32,
    parameter int N     = 3
);
    localparam int SEL_W = (N > 1) ? $clog2(N) : 1;

    logic [N*WIDTH-1:0] in_data;
    logic [SEL_W-1:0]   in_sel;
    logic               in_zero;
    logic               in_valid;
    logic               in_ready;
    logic               flush;
    logic [WIDTH-1:0]   out_data;
    logic               out_sel_err;
    logic               out_valid;
    logic               out_ready;

    modport master (
        output in_data, in_sel, in_zero, in_valid, flush, out_ready,
        input  in_ready, out_data, out_sel_err, out_valid
    );

    modport slave (
        input  in_data, in_sel, in_zero, in_valid, flush, out_ready,
        output in_ready, out_data, out_sel_err, out_valid
    );
endinterface

// File: rtl/sel_pipe_mux.sv
// sel_pipe_mux: N-to-1 lane select with a registered, back-pressurable
// output stage (main register plus one skid register).
// An out-of-range select yields DEFAULT and raises out_sel_err; in_zero
// forces a zero bubble. flush drops every held beat.
// Optional macro SEL_PIPE_MUX_STATS_EN adds xfer_cnt / err_cnt outputs.
module sel_pipe_mux #(
    parameter int               WIDTH   = 32,
    parameter int               N       = 3,
    parameter logic [WIDTH-1:0] DEFAULT = '0
) (
    input  logic         clk,
    input  logic         rst,
    sel_pipe_mux_if.slave bus
`ifdef SEL_PIPE_MUX_STATS_EN
    ,
    output logic [31:0]  xfer_cnt,
    output logic [15:0]  err_cnt
`endif
);
    localparam int SEL_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    // Returns {err, data} for one candidate beat. Every select value is
    // covered: the default is the out-of-range result and in-range lanes
    // override it; the bubble overrides everything.
    function automatic logic [WIDTH:0] pick_lane(
        input logic [N*WIDTH-1:0] data,
        input logic [SEL_W-1:0]   sel,
        input logic               zero
    );
        logic [WIDTH:0] res;
        res = {1'b1, DEFAULT};
        for (int i = 0; i < N; i++) begin
            if (sel == i[SEL_W-1:0]) begin
                res = {1'b0, data[i*WIDTH +: WIDTH]};
            end
        end
        if (zero) begin
            res = '0;
        end
        return res;
    endfunction

    state_t           state_q, state_d;
    logic [WIDTH-1:0] main_data_q, main_data_d;
    logic             main_err_q, main_err_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;
    logic             skid_err_q, skid_err_d;

    logic [WIDTH:0]   pick;
    logic             accept;
    logic             emit;

    assign pick = pick_lane(bus.in_data, bus.in_sel, bus.in_zero);

    // in_ready depends only on skid occupancy, flush and reset, never on
    // out_ready, so there is no combinational ready path through the block.
    assign bus.in_ready    = rst && !bus.flush && (state_q != ST_TWO);
    assign bus.out_valid   = (state_q != ST_EMPTY);
    assign bus.out_data    = main_data_q;
    assign bus.out_sel_err = main_err_q;

    assign accept = bus.in_valid && bus.in_ready;
    assign emit   = bus.out_valid && bus.out_ready;

    // Occupancy FSM and data steering between main and skid registers.
    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_err_d  = main_err_q;
        skid_data_d = skid_data_q;
        skid_err_d  = skid_err_q;

        if (bus.flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        main_data_d = pick[WIDTH-1:0];
                        main_err_d  = pick[WIDTH];
                        state_d     = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept && emit) begin
                        main_data_d = pick[WIDTH-1:0];
                        main_err_d  = pick[WIDTH];
                    end else if (accept) begin
                        skid_data_d = pick[WIDTH-1:0];
                        skid_err_d  = pick[WIDTH];
                        state_d     = ST_TWO;
                    end else if (emit) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (emit) begin
                        main_data_d = skid_data_q;
                        main_err_d  = skid_err_q;
                        state_d     = ST_ONE;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    // State and output (main) register; reset clears what the outputs show.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_EMPTY;
            main_data_q <= '0;
            main_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_err_q  <= main_err_d;
        end
    end

    // Skid register; its contents are meaningless unless state is TWO.
    always_ff @(posedge clk) begin
        skid_data_q <= skid_data_d;
        skid_err_q  <= skid_err_d;
    end

`ifdef SEL_PIPE_MUX_STATS_EN
    logic [31:0] xfer_cnt_q, xfer_cnt_d;
    logic [15:0] err_cnt_q, err_cnt_d;

    // Emit counters; a flush-cycle emit still counts as consumed.
    always_comb begin
        xfer_cnt_d = xfer_cnt_q;
        err_cnt_d  = err_cnt_q;
        if (emit) begin
            xfer_cnt_d = xfer_cnt_q + 32'd1;
            if (main_err_q) begin
                err_cnt_d = err_cnt_q + 16'd1;
            end
        end
    end

    // Counter registers, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            xfer_cnt_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            xfer_cnt_q <= xfer_cnt_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign xfer_cnt = xfer_cnt_q;
    assign err_cnt  = err_cnt_q;
`endif
endmodule

// File: doc/sel_pipe_mux.md
Name: sel_pipe_mux

Overview:
- Parametrised N-to-1 datapath select with a registered, back-pressurable output stage.
- Next generation of the pipeline operand/writeback muxes: any lane count and any width.
- Adds a defined out-of-range select result, a force-zero (bubble) control, a valid/ready handshake with a 2-entry skid buffer, and a flush.
- Sits between a pipeline stage's operand sources and the next stage register (ALU operand select, writeback select).

Parameters:
- WIDTH, 32, data width of each lane and of the output.
- N, 3, number of input lanes, must be ≥ 2.
- SEL_W, $clog2(N) (minimum 1), select width; derived, never overridden.
- DEFAULT, 0, WIDTH-bit value driven for an out-of-range select.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-low reset; sampled on the rising edge of clk.
- in_data  in  N*WIDTH  packed lanes; lane i at [i*WIDTH +: WIDTH].
- in_sel  in  SEL_W  lane select.
- in_zero  in  1  force the result to zero (bubble), overriding in_sel.
- in_valid  in  1  upstream has a beat.
- in_ready  out  1  block can accept a beat.
- flush  in  1  discard all held beats.
- out_data  out  WIDTH  selected value.
- out_sel_err  out  1  the beat held an out-of-range select.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts.

Behaviour:
- Accept: in_valid && in_ready on a rising edge.
- Emit: out_valid && out_ready on a rising edge.
- Result computed at accept:
  - in_zero=1 → data 0, err 0.
  - else in_sel < N → lane in_sel, err 0.
  - else → DEFAULT, err 1.
  - No latches; every select value is covered.
- Storage: main register (drives the outputs) plus one skid register.
  - EMPTY: no beats held; out_valid=0; in_ready=1.
  - ONE: main holds a beat; out_valid=1; in_ready=1.
  - TWO: main and skid both hold beats; out_valid=1; in_ready=0.
- Transitions:
  - EMPTY + accept → ONE.
  - ONE + accept + emit → ONE; the new beat goes to main.
  - ONE + accept, no emit → TWO; the new beat goes to skid.
  - ONE + emit, no accept → EMPTY.
  - TWO + emit → ONE; skid moves to main.
  - All other cases hold the current state.
- Latency: a beat accepted at edge k appears on out_data/out_valid after edge k (1 cycle) if main was empty or emitted at k.
- Ordering is strict FIFO; no beat is lost or duplicated.
- Registered outputs: in_ready is a function of skid occupancy only, gated by flush; no combinational path from out_ready to in_ready.
- flush=1:
  - Next state EMPTY.
  - in_ready forced 0 during that cycle, so a simultaneous in_valid is not accepted.
  - A simultaneous emit still counts as downstream-consumed.
- Reset (rst=0 at an edge), including mid-transfer:
  - State EMPTY; out_valid=0, out_data=0, out_sel_err=0.
  - in_ready=0 while rst=0, then 1 from the first cycle after release.
- out_data and out_sel_err stay stable while out_valid=1 and out_ready=0.

Optional Feature:
- Macro: SEL_PIPE_MUX_STATS_EN.
- When defined, add two output ports:
  - xfer_cnt (32): emit count.
  - err_cnt (16): emitted beats with out_sel_err=1.
- Both counters: cleared by reset, not by flush; wrap modulo 2^width.
- When undefined, the ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset: hold rst=0 for 3 cycles with in_valid=1 → out_valid=0, out_data=0, out_sel_err=0, in_ready=0; after release, in_ready=1 on the next cycle.
- Pass-through (N=3, WIDTH=32): lanes 0x11/0x22/0x33, sel=1, out_ready=1 → out_data=0x22, out_valid=1 one cycle after accept; sel=2 next cycle → 0x33.
- Backpressure: out_ready=0, send sel=0 then sel=2 → in_ready=0 after the 2nd accept; a 3rd beat is held off; release out_ready → 0x11 then 0x33 in order, then in_ready=1.
- Out-of-range: N=3, sel=3, DEFAULT=0xDEAD_BEEF → out_data=0xDEADBEEF, out_sel_err=1; with in_zero=1 and sel=3 → out_data=0, out_sel_err=0.
- Flush: TWO state plus in_valid=1 and flush=1 in the same cycle → next cycle out_valid=0 and no beat accepted; the following beat emits normally.
- Stats (SEL_PIPE_MUX_STATS_EN): 5 emits including 2 out-of-range → xfer_cnt=5, err_cnt=2; a flush leaves both unchanged; reset clears both to 0.
